// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - game round sequencer: attract, level load, serve countdown, play, game over, victory
// Every output is a register so no input reaches an output combinationally.
module round_sequencer #(
  parameter int LIVES_INIT  = 3,
  parameter int SERVE_DELAY = 60,
  parameter int LEVEL_MAX   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       ball_out_of_bounds,
  input  logic       all_bricks_cleared,
  output logic       start_game,
  output logic       ball_enable,
  output logic       brick_reload,
  output logic [2:0] lives,
  output logic [2:0] level,
  output logic [7:0] serve_cnt,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    ATTRACT   = 3'd0,
    LOAD      = 3'd1,
    SERVE     = 3'd2,
    PLAY      = 3'd3,
    GAME_OVER = 3'd4,
    VICTORY   = 3'd5
  } state_t;

  localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);
  localparam logic [2:0] LEVEL_TOP = 3'(LEVEL_MAX);
  localparam logic [7:0] SERVE_RST = 8'(SERVE_DELAY);

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [2:0] level_q, level_d;
  logic [7:0] serve_cnt_q, serve_cnt_d;
  logic       start_prev_q;
  logic       start_game_q, ball_enable_q, brick_reload_q;
  logic       start_press;

  // Previous-sample register resets high so a button held through reset is not a press.
  assign start_press = start_btn & ~start_prev_q;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    level_d     = level_q;
    serve_cnt_d = serve_cnt_q;
    case (state_q)
      ATTRACT, GAME_OVER, VICTORY: begin
        if (start_press) begin
          state_d = LOAD;
          lives_d = LIVES_RST;
          level_d = 3'd0;
        end
      end
      LOAD: begin
        state_d     = SERVE;
        serve_cnt_d = SERVE_RST;
      end
      SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_q <= 8'd1) begin
            serve_cnt_d = 8'd0;
            state_d     = PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q - 8'd1;
          end
        end
      end
      PLAY: begin
        // A cleared map wins over a simultaneous lost ball.
        if (all_bricks_cleared) begin
          if (level_q >= LEVEL_TOP) begin
            state_d = VICTORY;
          end else begin
            level_d = level_q + 3'd1;
            state_d = LOAD;
          end
        end else if (ball_out_of_bounds) begin
          if (lives_q <= 3'd1) begin
            lives_d = 3'd0;
            state_d = GAME_OVER;
          end else begin
            lives_d     = lives_q - 3'd1;
            serve_cnt_d = SERVE_RST;
            state_d     = SERVE;
          end
        end
      end
      default: state_d = ATTRACT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ATTRACT;
      lives_q        <= 3'd0;
      level_q        <= 3'd0;
      serve_cnt_q    <= 8'd0;
      start_prev_q   <= 1'b1;
      start_game_q   <= 1'b0;
      ball_enable_q  <= 1'b0;
      brick_reload_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      level_q        <= level_d;
      serve_cnt_q    <= serve_cnt_d;
      start_prev_q   <= start_btn;
      start_game_q   <= (state_d == PLAY) && (state_q != PLAY);
      ball_enable_q  <= (state_d == PLAY);
      brick_reload_q <= (state_d == LOAD);
    end
  end

  assign start_game   = start_game_q;
  assign ball_enable  = ball_enable_q;
  assign brick_reload = brick_reload_q;
  assign lives        = lives_q;
  assign level        = level_q;
  assign serve_cnt    = serve_cnt_q;
  assign state_out    = state_q;

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter LIVES_INIT, default 3, lives granted at game start (1..7).
REQ-002 Parameter SERVE_DELAY, default 60, frame ticks between ball placement and launch (1..255).
REQ-003 Parameter LEVEL_MAX, default 7, index of final level (0..7).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 start_btn  input  1  debounced start button level.
REQ-008 ball_out_of_bounds  input  1  ball lost; sampled only in PLAY.
REQ-009 all_bricks_cleared  input  1  brick map empty; sampled only in PLAY.
REQ-010 start_game  output  1  one-cycle pulse launching the ball.
REQ-011 ball_enable  output  1  high while in PLAY; ball motion permitted.
REQ-012 brick_reload  output  1  one-cycle pulse; brick map reloads for current level.
REQ-013 lives  output  3  remaining lives.
REQ-014 level  output  3  current level index.
REQ-015 serve_cnt  output  8  remaining serve frames, for display.
REQ-016 state_out  output  3  ATTRACT=0, LOAD=1, SERVE=2, PLAY=3, GAME_OVER=4, VICTORY=5.

Function
REQ-017 All outputs shall be registered; no combinational input-to-output path.
REQ-018 Start press = start_btn high while its previous-cycle sample is low; the previous-cycle sample register shall reset to 1, so a button held through reset does not start a game.
REQ-019 ATTRACT: on start press -> LOAD; lives <= LIVES_INIT, level <= 0; otherwise hold.
REQ-020 LOAD: exactly one cycle; brick_reload = 1 during it; next state SERVE with serve_cnt <= SERVE_DELAY.
REQ-021 SERVE: ball_enable = 0; on each frame_tick serve_cnt decrements by 1; the frame_tick that takes serve_cnt from 1 to 0 moves to PLAY on the next edge.
REQ-022 start_game shall be 1 exactly on the first cycle in PLAY and 0 at all other times.
REQ-023 PLAY: ball_enable = 1; all_bricks_cleared has priority over ball_out_of_bounds when both are high in the same cycle.
REQ-024 PLAY, all_bricks_cleared: if level == LEVEL_MAX -> VICTORY, level unchanged; else level <= level+1 -> LOAD.
REQ-025 PLAY, ball_out_of_bounds: lives <= lives-1; if lives was 1 -> GAME_OVER (lives = 0); else -> SERVE with serve_cnt <= SERVE_DELAY; no brick_reload.
REQ-026 GAME_OVER, VICTORY: hold; lives and level frozen; on start press -> LOAD with lives <= LIVES_INIT, level <= 0.
REQ-027 ball_out_of_bounds and all_bricks_cleared shall be ignored in every state other than PLAY; frame_tick shall be ignored outside SERVE.
REQ-028 lives shall never underflow below 0; level shall never exceed LEVEL_MAX.
REQ-029 An undefined state_out encoding shall return to ATTRACT on the next edge.

Reset
REQ-030 While rst = 1 at a clock edge: state ATTRACT, lives 0, level 0, serve_cnt 0, start_game 0, ball_enable 0, brick_reload 0, start sample register 1.
REQ-031 rst asserted in any state, including mid-SERVE or PLAY, shall take effect on that edge and override all other inputs.

Verification (bench: LIVES_INIT=3, SERVE_DELAY=2, LEVEL_MAX=1)
REQ-032 Reset, start press -> state 1 for one cycle with brick_reload=1, then state 2, serve_cnt=2; two frame_ticks -> state 3, start_game=1 for one cycle, lives=3, level=0.
REQ-033 In PLAY, three ball_out_of_bounds pulses, each followed by a full serve -> lives 2, 1, 0; final state 4; further ball_out_of_bounds leaves lives=0.
REQ-034 In PLAY at level 0, all_bricks_cleared -> level=1, LOAD, brick_reload pulse; cleared again at level 1 -> state 5, level stays 1.
REQ-035 In PLAY, all_bricks_cleared and ball_out_of_bounds in same cycle -> level advances, lives unchanged.
REQ-036 start_btn held high across reset release -> remains ATTRACT; release then press -> LOAD.
REQ-037 rst pulsed mid-SERVE with serve_cnt=1 -> all outputs at REQ-030 values on that edge; frame_tick after reset causes no state change.
